// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
// The loader writes the program memory that feeds the CPU's instruction fetch.
package prog_loader_pkg;

    localparam int INSN_W = 16;
    localparam int PROG_DEPTH = 256;
    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_COUNT = 3'd1,
        LD_OPC   = 3'd2,
        LD_IMM   = 3'd3,
        LD_SUM   = 3'd4
    } LOADER_STATE;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // A count byte of zero stands for a full 256-word image.
    function automatic logic [8:0] decode_count(input logic [7:0] n);
        return (n == 8'h00) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART byte receiver: synchronizes the asynchronous line, samples mid-bit,
// and drops bytes whose start bit is not confirmed or whose stop bit is low.
module prog_loader_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;

    // Synchronizer, falling-edge start detect and bit-timing state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // An edge is required, so a line held low after a framing error cannot retrigger.
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q <= '0;
                        if (!rx_sync_q) begin
                            state_q   <= RX_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Frame parser for the serial program loader: SYNC, count, opcode/imm pairs, checksum.
// Holds the CPU in reset during a load and after any failed load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CYC  = 2_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic                          mem_we,
    output logic [$clog2(PROG_DEPTH)-1:0] mem_addr,
    output logic [INSN_W-1:0]             mem_wdata,
    output logic                          cpu_hold,
    output logic                          busy,
    output logic                          load_done,
    output logic                          load_err
);

    localparam int AW    = $clog2(PROG_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]        rx_data_s;
    logic              rx_valid_s;
    logic              frame_err_unused;

    LOADER_STATE       state_q;
    logic [8:0]        remaining_q;
    logic [7:0]        sum_q;
    logic [7:0]        sum_d;
    logic [7:0]        opc_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [INSN_W-1:0] mem_wdata_q;
    logic              cpu_hold_q;
    logic              busy_q;
    logic              load_done_q;
    logic              load_err_q;

    prog_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (rx_data_s),
        .valid     (rx_valid_s),
        .frame_err (frame_err_unused)
    );

    assign sum_d = sum_q + rx_data_s;

    // Frame FSM with checksum, word address, remaining count and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            remaining_q <= 9'd0;
            sum_q       <= 8'h00;
            opc_q       <= 8'h00;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + AW'(1);
            end
            if (state_q != LD_IDLE && !rx_valid_s && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                // Stalled frame: abort but keep the CPU held, the image is incomplete.
                state_q    <= LD_IDLE;
                busy_q     <= 1'b0;
                load_err_q <= 1'b1;
                tmo_q      <= '0;
            end else begin
                if (rx_valid_s || state_q == LD_IDLE) begin
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
                case (state_q)
                    LD_IDLE: begin
                        if (rx_valid_s && rx_data_s == LOADER_SYNC) begin
                            state_q    <= LD_COUNT;
                            busy_q     <= 1'b1;
                            cpu_hold_q <= 1'b1;
                            load_err_q <= 1'b0;
                            sum_q      <= 8'h00;
                            mem_addr_q <= '0;
                        end
                    end
                    LD_COUNT: begin
                        if (rx_valid_s) begin
                            remaining_q <= decode_count(rx_data_s);
                            sum_q       <= rx_data_s;
                            state_q     <= LD_OPC;
                        end
                    end
                    LD_OPC: begin
                        if (rx_valid_s) begin
                            opc_q   <= rx_data_s;
                            sum_q   <= sum_d;
                            state_q <= LD_IMM;
                        end
                    end
                    LD_IMM: begin
                        // Written before the checksum is known; a bad frame keeps the hold asserted.
                        if (rx_valid_s) begin
                            sum_q       <= sum_d;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= {opc_q, rx_data_s};
                            remaining_q <= remaining_q - 9'd1;
                            state_q     <= (remaining_q == 9'd1) ? LD_SUM : LD_OPC;
                        end
                    end
                    LD_SUM: begin
                        if (rx_valid_s) begin
                            state_q <= LD_IDLE;
                            busy_q  <= 1'b0;
                            if (sum_d == 8'h00) begin
                                load_done_q <= 1'b1;
                                cpu_hold_q  <= 1'b0;
                            end else begin
                                load_err_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= LD_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: serial frames driven bit by bit, writes and
// status compared against expectations built from the frame contents.
module tb_prog_loader;
    import prog_loader_pkg::INSN_W;

    localparam int CPB = 4;
    localparam int TMO = 200;
    localparam int GAP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx = 1'b1;
    logic              mem_we;
    logic [7:0]        mem_addr;
    logic [INSN_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic              load_err;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int done_bad = 0;
    int exp_done = 0;
    logic prev_hold = 1'b0;
    logic [23:0] wq[$];
    logic [23:0] ew[$];
    logic [7:0] opc_a[256];
    logic [7:0] imm_a[256];

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Capture writes and check that load_done coincides with the hold release.
    always @(negedge clk) begin
        if (rst_n && mem_we) wq.push_back({mem_addr, mem_wdata});
        if (rst_n && load_done) begin
            done_cnt <= done_cnt + 1;
            if (!(cpu_hold == 1'b0 && prev_hold == 1'b1)) done_bad <= done_bad + 1;
        end
        prev_hold <= cpu_hold;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, wq.size(), ew.size());
        n = (wq.size() < ew.size()) ? wq.size() : ew.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, {8'h00, wq[i]}, {8'h00, ew[i]});
        wq.delete();
        ew.delete();
    endtask

    task automatic send_frame(input string tag, input int n, input logic [7:0] cs_delta);
        logic [7:0] nb;
        logic [7:0] s;
        logic [7:0] c;
        bit good;
        nb = n[7:0];
        s = nb;
        for (int i = 0; i < n; i++) begin
            s = s + opc_a[i] + imm_a[i];
            ew.push_back({i[7:0], opc_a[i], imm_a[i]});
        end
        c = 8'h00 - s + cs_delta;
        good = (cs_delta == 8'h00);
        send_byte(8'hA5);
        send_byte(nb);
        check({tag, "_hold_mid"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
        check({tag, "_err_mid"}, {31'd0, load_err}, 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(opc_a[i]);
            send_byte(imm_a[i]);
        end
        send_byte(c);
        repeat (8) @(negedge clk);
        if (good) exp_done++;
        check_writes(tag);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_err"}, {31'd0, load_err}, good ? 32'd0 : 32'd1);
        check({tag, "_hold"}, {31'd0, cpu_hold}, good ? 32'd0 : 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_addr_end"}, {24'd0, mem_addr}, {24'd0, nb});
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            opc_a[i] = 8'($urandom_range(0, 255));
            imm_a[i] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        logic [7:0] junk;
        int n;
        logic [7:0] delta;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // A5 02 01 10 05 20 C8
        opc_a[0] = 8'h01; imm_a[0] = 8'h10;
        opc_a[1] = 8'h05; imm_a[1] = 8'h20;
        send_frame("good2", 2, 8'h00);
        // Same image with C = C9, then a good random frame
        send_frame("bad2", 2, 8'h01);
        fill_random(3);
        send_frame("recover", 3, 8'h00);

        // Leading junk, in-frame A5 as opcode: A5 01 A5 00 5A
        send_byte(8'h3C);
        send_byte(8'h7F);
        check("junk_busy", {31'd0, busy}, 32'd0);
        opc_a[0] = 8'hA5; imm_a[0] = 8'h00;
        send_frame("inA5", 1, 8'h00);

        // Full 256-word image, address wraps to 0
        fill_random(256);
        send_frame("full256", 256, 8'h00);

        // Randomized frames, some with corrupted checksum and leading junk
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            n = $urandom_range(1, 6);
            fill_random(n);
            delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame("rand", n, delta);
        end

        // Timeout: A5 03 11 22 then idle
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        ew.push_back({8'h00, 8'h11, 8'h22});
        repeat (TMO + 60) @(negedge clk);
        check_writes("tmo");
        check("tmo_err", {31'd0, load_err}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_hold", {31'd0, cpu_hold}, 32'd1);
        repeat (50) @(negedge clk);
        check("tmo_no_more_wr", wq.size(), 32'd0);

        // Framing-error byte inside a frame is dropped: A5 01 [77 bad stop] 12 34 B9
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h77, 1'b0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hB9);
        repeat (8) @(negedge clk);
        exp_done++;
        ew.push_back({8'h00, 8'h12, 8'h34});
        check_writes("ferr");
        check("ferr_done_cnt", done_cnt, exp_done);
        check("ferr_err", {31'd0, load_err}, 32'd0);
        check("ferr_hold", {31'd0, cpu_hold}, 32'd0);

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h10);
        check("mid_hold", {31'd0, cpu_hold}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_we", {31'd0, mem_we}, 32'd0);
        check("mrst_addr", {24'd0, mem_addr}, 32'd0);
        check("mrst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("mrst_hold", {31'd0, cpu_hold}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, load_done}, 32'd0);
        check("mrst_err", {31'd0, load_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ew.push_back({8'h00, 8'h01, 8'h10});
        check_writes("mrst");
        fill_random(4);
        send_frame("after_rst", 4, 8'h00);

        check("done_hold_align", done_bad, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
